mem_bus_arbiter: RTL and testbench

//  Shares one Wishbone-style memory bus between instruction fetch (IF) and the MEM-stage data port.

---
 rtl/mem_bus_arbiter_pkg.sv | 14 +
 rtl/mem_bus_arbiter_grant.sv | 21 ++
 rtl/mem_bus_arbiter.sv | 97 +++++++++
 tb/tb_mem_bus_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: state codes and grant identifiers shared by the IF/MEM bus arbiter.
package mem_bus_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2,
    ARB_ABORT  = 2'd3
  } arb_state_e;
  typedef enum logic {
    ARB_GNT_IF  = 1'b0,
    ARB_GNT_MEM = 1'b1
  } arb_gnt_e;
  localparam logic [3:0] SEL_WORD = 4'b1111;
endpackage

// File: rtl/mem_bus_arbiter_grant.sv
// mem_bus_arbiter_grant: combinational winner select; ARB_ROUND_ROBIN_EN alternates on contention.
module mem_bus_arbiter_grant
  import mem_bus_arbiter_pkg::*;
(
  input  logic     if_req,
  input  logic     mem_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  arb_gnt_e last_grant,
`endif
  output logic     valid,
  output arb_gnt_e gnt
);
  assign valid = if_req | mem_req;
`ifdef ARB_ROUND_ROBIN_EN
  assign gnt = (if_req & mem_req) ? ((last_grant == ARB_GNT_IF) ? ARB_GNT_MEM : ARB_GNT_IF)
                                  : (mem_req ? ARB_GNT_MEM : ARB_GNT_IF);
`else
  // MEM holds the older instruction, so it wins on contention
  assign gnt = mem_req ? ARB_GNT_MEM : ARB_GNT_IF;
`endif
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one registered Wishbone-style bus between IF and MEM; ARB_ROUND_ROBIN_EN selects alternating priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stallreq_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_stallreq_o,
  output logic              bus_cyc_o,
  output logic              bus_stb_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i
);
  arb_state_e state;
  arb_gnt_e   gnt;
  logic       gnt_valid, done_i, done_d, busy;
`ifdef ARB_ROUND_ROBIN_EN
  arb_gnt_e   last_grant;
`endif
  assign busy = (state == ARB_BUSY_I) | (state == ARB_BUSY_D);
  assign if_stallreq_o  = ~rst & ((if_ce_i & ~done_i) | (state == ARB_ABORT));
  assign mem_stallreq_o = ~rst & ((mem_ce_i & ~done_d) | (state == ARB_ABORT));
  mem_bus_arbiter_grant u_grant (
    .if_req     (if_ce_i & ~done_i),
    .mem_req    (mem_ce_i & ~done_d),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant (last_grant),
`endif
    .valid      (gnt_valid),
    .gnt        (gnt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      done_i      <= 1'b0;
      done_d      <= 1'b0;
      if_rdata_o  <= '0;
      mem_rdata_o <= '0;
      bus_cyc_o   <= 1'b0;
      bus_stb_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant  <= ARB_GNT_IF;
`endif
    end else begin
      done_i <= 1'b0;
      done_d <= 1'b0;
      if (state != ARB_IDLE && bus_ack_i) begin
        state       <= ARB_IDLE;
        bus_cyc_o   <= 1'b0;
        bus_stb_o   <= 1'b0;
        bus_we_o    <= 1'b0;
        bus_sel_o   <= '0;
        bus_addr_o  <= '0;
        bus_wdata_o <= '0;
        // an ack that lands in ABORT is swallowed: no data, no done pulse
        done_i <= state == ARB_BUSY_I;
        done_d <= state == ARB_BUSY_D;
        if (state == ARB_BUSY_I) if_rdata_o <= bus_rdata_i;
        if (state == ARB_BUSY_D && !bus_we_o) mem_rdata_o <= bus_rdata_i;
      end else if (busy && flush) begin
        state <= ARB_ABORT;
      end else if (state == ARB_IDLE && gnt_valid) begin
        state       <= (gnt == ARB_GNT_MEM) ? ARB_BUSY_D : ARB_BUSY_I;
        bus_cyc_o   <= 1'b1;
        bus_stb_o   <= 1'b1;
        bus_we_o    <= (gnt == ARB_GNT_MEM) ? mem_we_i : 1'b0;
        bus_sel_o   <= (gnt == ARB_GNT_MEM) ? mem_sel_i : SEL_WORD;
        bus_addr_o  <= (gnt == ARB_GNT_MEM) ? mem_addr_i : if_addr_i;
        bus_wdata_o <= (gnt == ARB_GNT_MEM) ? mem_wdata_i : '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant  <= gnt;
`endif
      end
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of grant order, bus timing, flush/abort and reset for mem_bus_arbiter.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        if_ce_i = 1'b0, mem_ce_i = 1'b0, mem_we_i = 1'b0, bus_ack_i = 1'b0;
  logic [31:0] if_addr_i = '0, mem_addr_i = '0, mem_wdata_i = '0, bus_rdata_i = '0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] if_rdata_o, mem_rdata_o, bus_addr_o, bus_wdata_o;
  logic        if_stallreq_o, mem_stallreq_o, bus_cyc_o, bus_stb_o, bus_we_o;
  logic [3:0]  bus_sel_o;
  int          errors = 0, checks = 0;
  logic        first_mem;
  logic [31:0] first_addr, second_addr, first_data, second_data;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_stallreq_o(if_stallreq_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_stallreq_o(mem_stallreq_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    if_ce_i = 1'b1;
    step();
    step();
    chk("rst_cyc", {31'd0, bus_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, bus_stb_o}, 32'd0);
    chk("rst_addr", bus_addr_o, 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_mem_rdata", mem_rdata_o, 32'd0);
    chk("rst_if_stall", {31'd0, if_stallreq_o}, 32'd0);
    if_ce_i = 1'b0;
    rst = 1'b0;
    step();
    // 1: IF alone with two wait states
    if_ce_i = 1'b1;
    if_addr_i = 32'h100;
    #1;
    chk("t1_stall_req", {31'd0, if_stallreq_o}, 32'd1);
    step();
    chk("t1_stb_c1", {31'd0, bus_stb_o}, 32'd1);
    chk("t1_we", {31'd0, bus_we_o}, 32'd0);
    chk("t1_sel", {28'd0, bus_sel_o}, 32'hF);
    chk("t1_addr", bus_addr_o, 32'h100);
    step();
    chk("t1_stb_c2", {31'd0, bus_stb_o}, 32'd1);
    step();
    chk("t1_stb_c3", {31'd0, bus_stb_o}, 32'd1);
    bus_ack_i = 1'b1;
    bus_rdata_i = 32'h3C011234;
    #1;
    chk("t1_stall_at_ack", {31'd0, if_stallreq_o}, 32'd1);
    step();
    bus_ack_i = 1'b0;
    chk("t1_cyc_clr", {31'd0, bus_cyc_o}, 32'd0);
    chk("t1_stb_clr", {31'd0, bus_stb_o}, 32'd0);
    chk("t1_rdata", if_rdata_o, 32'h3C011234);
    chk("t1_stall_rel", {31'd0, if_stallreq_o}, 32'd0);
    if_ce_i = 1'b0;
    step();
    chk("t1_idle", {31'd0, bus_cyc_o}, 32'd0);
    // 3: MEM byte store, read data must stay put
    mem_ce_i = 1'b1;
    mem_we_i = 1'b1;
    mem_sel_i = 4'b0001;
    mem_addr_i = 32'h203;
    mem_wdata_i = 32'h000000AA;
    step();
    chk("t3_cyc", {31'd0, bus_cyc_o}, 32'd1);
    chk("t3_we", {31'd0, bus_we_o}, 32'd1);
    chk("t3_sel", {28'd0, bus_sel_o}, 32'h1);
    chk("t3_addr", bus_addr_o, 32'h203);
    chk("t3_wdata", bus_wdata_o, 32'hAA);
    bus_ack_i = 1'b1;
    bus_rdata_i = 32'h55555555;
    step();
    bus_ack_i = 1'b0;
    chk("t3_cyc_clr", {31'd0, bus_cyc_o}, 32'd0);
    chk("t3_rdata_kept", mem_rdata_o, 32'd0);
    chk("t3_stall_rel", {31'd0, mem_stallreq_o}, 32'd0);
    mem_ce_i = 1'b0;
    mem_we_i = 1'b0;
    step();
    // 2: simultaneous IF and MEM load; last grant was MEM
`ifdef ARB_ROUND_ROBIN_EN
    first_mem = 1'b0;
`else
    first_mem = 1'b1;
`endif
    first_addr  = first_mem ? 32'h200 : 32'h104;
    second_addr = first_mem ? 32'h104 : 32'h200;
    first_data  = first_mem ? 32'h11223344 : 32'h24420001;
    second_data = first_mem ? 32'h24420001 : 32'h11223344;
    if_ce_i = 1'b1;
    if_addr_i = 32'h104;
    mem_ce_i = 1'b1;
    mem_sel_i = 4'b1111;
    mem_addr_i = 32'h200;
    step();
    chk("t2_first_addr", bus_addr_o, first_addr);
    chk("t2_first_we", {31'd0, bus_we_o}, 32'd0);
    chk("t2_if_stall", {31'd0, if_stallreq_o}, 32'd1);
    chk("t2_mem_stall", {31'd0, mem_stallreq_o}, 32'd1);
    bus_ack_i = 1'b1;
    bus_rdata_i = first_data;
    step();
    bus_ack_i = 1'b0;
    chk("t2_gap_cyc", {31'd0, bus_cyc_o}, 32'd0);
    chk("t2_first_rdata", first_mem ? mem_rdata_o : if_rdata_o, first_data);
    chk("t2_first_stall", {31'd0, first_mem ? mem_stallreq_o : if_stallreq_o}, 32'd0);
    chk("t2_second_stall", {31'd0, first_mem ? if_stallreq_o : mem_stallreq_o}, 32'd1);
    if (first_mem) mem_ce_i = 1'b0; else if_ce_i = 1'b0;
    step();
    chk("t2_second_cyc", {31'd0, bus_cyc_o}, 32'd1);
    chk("t2_second_addr", bus_addr_o, second_addr);
    bus_ack_i = 1'b1;
    bus_rdata_i = second_data;
    step();
    bus_ack_i = 1'b0;
    chk("t2_second_rdata", first_mem ? if_rdata_o : mem_rdata_o, second_data);
    chk("t2_first_rdata_held", first_mem ? mem_rdata_o : if_rdata_o, first_data);
    if_ce_i = 1'b0;
    mem_ce_i = 1'b0;
    step();
    // 4: flush during a MEM load
    mem_ce_i = 1'b1;
    mem_addr_i = 32'h300;
    step();
    chk("t4_cyc", {31'd0, bus_cyc_o}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_abort_cyc", {31'd0, bus_cyc_o}, 32'd1);
    chk("t4_abort_addr", bus_addr_o, 32'h300);
    chk("t4_abort_if_stall", {31'd0, if_stallreq_o}, 32'd1);
    chk("t4_abort_mem_stall", {31'd0, mem_stallreq_o}, 32'd1);
    mem_ce_i = 1'b0;
    bus_ack_i = 1'b1;
    bus_rdata_i = 32'hDEADBEEF;
    step();
    bus_ack_i = 1'b0;
    chk("t4_cyc_clr", {31'd0, bus_cyc_o}, 32'd0);
    chk("t4_rdata_kept", mem_rdata_o, first_mem ? first_data : second_data);
    chk("t4_if_stall_rel", {31'd0, if_stallreq_o}, 32'd0);
    chk("t4_mem_stall_rel", {31'd0, mem_stallreq_o}, 32'd0);
    step();
    chk("t4_idle", {31'd0, bus_cyc_o}, 32'd0);
    // 5: reset in the middle of an IF access, then a stray ack
    if_ce_i = 1'b1;
    if_addr_i = 32'h400;
    step();
    chk("t5_cyc", {31'd0, bus_cyc_o}, 32'd1);
    rst = 1'b1;
    step();
    chk("t5_rst_cyc", {31'd0, bus_cyc_o}, 32'd0);
    chk("t5_rst_addr", bus_addr_o, 32'd0);
    chk("t5_rst_if_rdata", if_rdata_o, 32'd0);
    chk("t5_rst_stall", {31'd0, if_stallreq_o}, 32'd0);
    rst = 1'b0;
    if_ce_i = 1'b0;
    bus_ack_i = 1'b1;
    bus_rdata_i = 32'h99999999;
    step();
    bus_ack_i = 1'b0;
    chk("t5_late_ack_cyc", {31'd0, bus_cyc_o}, 32'd0);
    chk("t5_late_ack_rdata", if_rdata_o, 32'd0);
    step();
    // 6: back-to-back zero-wait IF fetches, one every three cycles
    if_ce_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_addr_i = 32'h500 + 32'(k * 4);
      #1;
      chk("t6_idle_cyc", {31'd0, bus_cyc_o}, 32'd0);
      chk("t6_idle_stall", {31'd0, if_stallreq_o}, 32'd1);
      step();
      chk("t6_bus_addr", bus_addr_o, 32'h500 + 32'(k * 4));
      bus_ack_i = 1'b1;
      bus_rdata_i = 32'hA0000000 + 32'(k);
      step();
      bus_ack_i = 1'b0;
      chk("t6_rdata", if_rdata_o, 32'hA0000000 + 32'(k));
      chk("t6_done_stall", {31'd0, if_stallreq_o}, 32'd0);
      if_addr_i = 32'h500 + 32'((k + 1) * 4);
      step();
      chk("t6_no_reissue", {31'd0, bus_cyc_o}, 32'd0);
    end
    if_ce_i = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
